// File: rtl/ati_bus_bridge.sv
// rtl/ati_bus_bridge.sv - ATI system bus slave bridge to a narrow-data peripheral with TX/RX word FIFOs
module ati_bus_bridge_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push on full still lands
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

module ati_bus_bridge #(
    parameter int DATA_BUS_WIDTH    = 64,
    parameter int ADDR_BUS_WIDTH    = 64,
    parameter int CHANNEL_WIDTH     = 2,
    parameter int DEVICE_CHANNEL_ID = 0,
    parameter int DEVICE_DATA_WIDTH = 8,
    parameter int TX_DEPTH          = 4,
    parameter int RX_DEPTH          = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [ADDR_BUS_WIDTH-1:0]    bus_addr,
    input  logic [DATA_BUS_WIDTH-1:0]    bus_wdata,
    input  logic [1:0]                   bus_dtype,
    input  logic                         bus_wr_req,
    input  logic                         bus_rd_req,
    output logic                         bus_sel,
    output logic                         bus_wr_ready,
    output logic [DATA_BUS_WIDTH-1:0]    bus_rdata,
    output logic                         bus_rd_valid,
    output logic                         bus_err,
    output logic                         tx_ovf_sticky,
    output logic [DEVICE_DATA_WIDTH-1:0] dev_wdata,
    output logic                         dev_wr_valid,
    input  logic                         dev_wr_ready,
    input  logic [DEVICE_DATA_WIDTH-1:0] dev_rdata,
    input  logic                         dev_rd_valid,
    output logic                         dev_rd_ready,
    input  logic [1:0]                   cfg_rx_dtype
);
    localparam int MAX_BEATS = DATA_BUS_WIDTH / DEVICE_DATA_WIDTH;
    localparam int CNT_W     = $clog2(MAX_BEATS + 1);
    localparam int TXW       = DATA_BUS_WIDTH + 2;
    localparam int TX_CW     = $clog2(TX_DEPTH) + 1;
    localparam int RX_CW     = $clog2(RX_DEPTH) + 1;

    typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
    typedef enum logic {RX_ASM, RX_HOLD}  rx_state_t;

    function automatic logic [CNT_W-1:0] n_beats(input logic [1:0] t);
        int w;
        w = 8 << t;
        if (w > DATA_BUS_WIDTH) w = DATA_BUS_WIDTH;
        if (w <= DEVICE_DATA_WIDTH) return CNT_W'(1);
        return CNT_W'(w / DEVICE_DATA_WIDTH);
    endfunction

    function automatic logic [DATA_BUS_WIDTH-1:0] type_mask(input logic [1:0] t);
        logic [DATA_BUS_WIDTH-1:0] m;
        for (int i = 0; i < DATA_BUS_WIDTH; i++) m[i] = (i < (8 << t));
        return m;
    endfunction

    // The address offset below the channel field is decoded upstream
    logic unused_addr;
    assign unused_addr = ^bus_addr[ADDR_BUS_WIDTH-CHANNEL_WIDTH-1:0];

    assign bus_sel = (bus_addr[ADDR_BUS_WIDTH-1 -: CHANNEL_WIDTH] == CHANNEL_WIDTH'(DEVICE_CHANNEL_ID));

    logic                 tx_push;
    logic                 tx_pop;
    logic [TXW-1:0]       tx_head;
    logic [TX_CW-1:0]     tx_count;
    logic                 tx_full;
    logic                 tx_empty;
    logic                 wr_drop;

    assign tx_full      = (tx_count == TX_CW'(TX_DEPTH));
    assign tx_empty     = (tx_count == '0);
    assign tx_push      = bus_sel && bus_wr_req && !tx_full;
    assign wr_drop      = bus_sel && bus_wr_req && tx_full;
    assign bus_wr_ready = bus_sel && !tx_full;

    ati_bus_bridge_fifo #(.WIDTH(TXW), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (tx_push),
        .push_data ({bus_wdata, bus_dtype}),
        .pop       (tx_pop),
        .head      (tx_head),
        .count     (tx_count)
    );

    tx_state_t                  tx_state;
    tx_state_t                  tx_state_next;
    logic [CNT_W-1:0]           beat_idx;
    logic [CNT_W-1:0]           beat_idx_next;
    logic                       tx_last;
    logic [DATA_BUS_WIDTH-1:0]  tx_word;
    logic [31:0]                tx_sh;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            beat_idx <= '0;
        end else begin
            tx_state <= tx_state_next;
            beat_idx <= beat_idx_next;
        end
    end

    // Beat count follows the head entry directly; the head only changes on a pop
    always_comb begin
        tx_state_next = tx_state;
        beat_idx_next = beat_idx;
        tx_pop        = 1'b0;
        tx_last       = ((beat_idx + CNT_W'(1)) == n_beats(tx_head[1:0]));
        case (tx_state)
            TX_IDLE: begin
                if (!tx_empty) begin
                    tx_state_next = TX_SEND;
                    beat_idx_next = '0;
                end
            end
            TX_SEND: begin
                if (dev_wr_ready) begin
                    if (tx_last) begin
                        tx_pop        = 1'b1;
                        beat_idx_next = '0;
                        if (tx_count <= TX_CW'(1)) tx_state_next = TX_IDLE;
                    end else begin
                        beat_idx_next = beat_idx + CNT_W'(1);
                    end
                end
            end
            default: tx_state_next = TX_IDLE;
        endcase
    end

    assign tx_word      = tx_head[TXW-1:2] & type_mask(tx_head[1:0]);
    assign tx_sh        = 32'(beat_idx) * DEVICE_DATA_WIDTH;
    assign dev_wr_valid = (tx_state == TX_SEND);
    assign dev_wdata    = dev_wr_valid ? DEVICE_DATA_WIDTH'(tx_word >> tx_sh) : '0;

    logic                       rx_push;
    logic                       rx_pop;
    logic [DATA_BUS_WIDTH-1:0]  rx_push_data;
    logic [DATA_BUS_WIDTH-1:0]  rx_head;
    logic [RX_CW-1:0]           rx_count;
    logic                       rx_full;
    logic                       rx_empty;
    logic                       rx_space;
    logic                       rd_err;

    assign rx_full  = (rx_count == RX_CW'(RX_DEPTH));
    assign rx_empty = (rx_count == '0);
    assign rx_pop   = bus_sel && bus_rd_req && !rx_empty;
    assign rd_err   = bus_sel && bus_rd_req && rx_empty;
    assign rx_space = !rx_full || rx_pop;

    ati_bus_bridge_fifo #(.WIDTH(DATA_BUS_WIDTH), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rx_push),
        .push_data (rx_push_data),
        .pop       (rx_pop),
        .head      (rx_head),
        .count     (rx_count)
    );

    rx_state_t                  rx_state;
    rx_state_t                  rx_state_next;
    logic [CNT_W-1:0]           rx_idx;
    logic [CNT_W-1:0]           rx_idx_next;
    logic [1:0]                 rx_type;
    logic [1:0]                 rx_type_next;
    logic [1:0]                 rx_cur_type;
    logic [DATA_BUS_WIDTH-1:0]  rx_acc;
    logic [DATA_BUS_WIDTH-1:0]  rx_acc_next;
    logic [DATA_BUS_WIDTH-1:0]  rx_beat;
    logic [DATA_BUS_WIDTH-1:0]  rx_merged;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state <= RX_ASM;
            rx_idx   <= '0;
            rx_type  <= 2'b00;
            rx_acc   <= '0;
        end else begin
            rx_state <= rx_state_next;
            rx_idx   <= rx_idx_next;
            rx_type  <= rx_type_next;
            rx_acc   <= rx_acc_next;
        end
    end

    always_comb begin
        rx_state_next = rx_state;
        rx_idx_next   = rx_idx;
        rx_type_next  = rx_type;
        rx_acc_next   = rx_acc;
        rx_push       = 1'b0;
        rx_push_data  = rx_acc;
        rx_beat       = '0;
        rx_beat[DEVICE_DATA_WIDTH-1:0] = dev_rdata;
        // First beat of a word takes the live type and starts from a zeroed accumulator
        rx_cur_type   = (rx_idx == '0) ? cfg_rx_dtype : rx_type;
        rx_merged     = ((rx_idx == '0) ? '0 : rx_acc) | (rx_beat << (32'(rx_idx) * DEVICE_DATA_WIDTH));
        case (rx_state)
            RX_ASM: begin
                if (dev_rd_valid) begin
                    rx_type_next = rx_cur_type;
                    if ((rx_idx + CNT_W'(1)) == n_beats(rx_cur_type)) begin
                        rx_idx_next  = '0;
                        rx_push_data = rx_merged & type_mask(rx_cur_type);
                        if (rx_space) begin
                            rx_push = 1'b1;
                        end else begin
                            rx_acc_next   = rx_merged & type_mask(rx_cur_type);
                            rx_state_next = RX_HOLD;
                        end
                    end else begin
                        rx_acc_next = rx_merged;
                        rx_idx_next = rx_idx + CNT_W'(1);
                    end
                end
            end
            RX_HOLD: begin
                if (rx_space) begin
                    rx_push       = 1'b1;
                    rx_state_next = RX_ASM;
                end
            end
            default: rx_state_next = RX_ASM;
        endcase
    end

    assign dev_rd_ready = rst_n && (rx_state == RX_ASM);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus_rd_valid  <= 1'b0;
            bus_rdata     <= '0;
            bus_err       <= 1'b0;
            tx_ovf_sticky <= 1'b0;
        end else begin
            bus_rd_valid <= rx_pop;
            bus_rdata    <= rx_pop ? rx_head : '0;
            bus_err      <= wr_drop || rd_err;
            if (wr_drop) tx_ovf_sticky <= 1'b1;
        end
    end
endmodule
